// File: rtl/ram_sync_clr.sv
// ram_sync_clr: single-port synchronous RAM with a registered read port,
// a one-cycle read-valid strobe, a selectable read-during-write behaviour
// and a self-clearing sweep that runs after every reset.
//
// After reset the block walks every word from address 0 up to DEPTH-1 and
// writes INIT_VAL into each one. It does this one word per clock while busy
// is high. Requests that arrive during the sweep are ignored. Once the sweep
// finishes, the block serves one read and/or one write per clock at the
// shared address. Accesses to addresses at or above DEPTH do not touch
// storage: writes are dropped and reads return INIT_VAL.

module ram_sync_clr #(
  parameter int                 DATA_W   = 4,
  parameter int                 ADDR_W   = 4,
  parameter int                 DEPTH    = 16,
  parameter int                 RDW_MODE = 0,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic              ren,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] qout,
  output logic              qvalid,
  output logic              busy
);

  // Last word touched by the sweep, and the depth widened by one bit so the
  // range test stays exact when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic              WRITE_FIRST = (RDW_MODE != 0);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Architectural state
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   qout_q, qout_d;
  logic                qvalid_q, qvalid_d;

  // Storage. It is deliberately not reset; the sweep gives it known contents.
  logic [DATA_W-1:0]   mem_q [0:DEPTH-1];

  // Single write port into storage
  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_waddr_s;
  logic [DATA_W-1:0]   mem_wdata_s;

  // Read path helpers
  logic                in_range_s;
  logic [DATA_W-1:0]   rd_word_s;
  logic [DATA_W-1:0]   rd_data_s;

  // Decode whether the request address maps onto a physical word.
  always_comb begin
    in_range_s = ({1'b0, addr} < DEPTH_EXT);
  end

  // Pick the value a read returns this cycle, including read-during-write.
  always_comb begin
    rd_word_s = mem_q[addr];
    if (!in_range_s) begin
      rd_data_s = INIT_VAL;
    end else if (WRITE_FIRST && wen) begin
      rd_data_s = din;
    end else begin
      rd_data_s = rd_word_s;
    end
  end

  // Sequencing: the clear sweep, request handling and next output values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    qout_d      = qout_q;
    qvalid_d    = 1'b0;
    mem_we_s    = 1'b0;
    mem_waddr_s = cnt_q;
    mem_wdata_s = INIT_VAL;

    case (state_q)
      ST_CLEAR: begin
        // The sweep ignores wen/ren and keeps qout unchanged.
        mem_we_s    = 1'b1;
        mem_waddr_s = cnt_q;
        mem_wdata_s = INIT_VAL;
        qvalid_d    = 1'b0;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
          busy_d  = 1'b1;
        end
      end

      ST_IDLE: begin
        busy_d = 1'b0;
        if (wen && in_range_s) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = addr;
          mem_wdata_s = din;
        end else begin
          mem_we_s    = 1'b0;
        end
        if (ren) begin
          qout_d   = rd_data_s;
          qvalid_d = 1'b1;
        end else begin
          qvalid_d = 1'b0;
        end
      end

      default: begin
        // An illegal encoding falls back into a fresh sweep.
        state_d  = ST_CLEAR;
        cnt_d    = '0;
        busy_d   = 1'b1;
        qvalid_d = 1'b0;
      end
    endcase

    // A reset edge never writes storage.
    if (rst) begin
      mem_we_s = 1'b0;
    end else begin
      mem_we_s = mem_we_s;
    end
  end

  // Control and output registers, with a synchronous reset that restarts the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_CLEAR;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
      qout_q   <= '0;
      qvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      qout_q   <= qout_d;
      qvalid_q <= qvalid_d;
    end
  end

  // Storage write port, used by both the sweep and normal writes.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign qout   = qout_q;
  assign qvalid = qvalid_q;
  assign busy   = busy_q;

endmodule
